// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding,
// 2-bit sticky result encoding and its lt/gt/eq decode.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_LT   = 2'd1,
    RES_GT   = 2'd2,
    RES_EQ   = 2'd3
  } res_t;

  // {lt, gt, eq} patterns
  localparam logic [2:0] LGE_NONE = 3'b000;
  localparam logic [2:0] LGE_LT   = 3'b100;
  localparam logic [2:0] LGE_GT   = 3'b010;
  localparam logic [2:0] LGE_EQ   = 3'b001;

  function automatic logic [2:0] res_decode(res_t r);
    case (r)
      RES_LT:  return LGE_LT;
      RES_GT:  return LGE_GT;
      RES_EQ:  return LGE_EQ;
      default: return LGE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_bitcmp.sv
// Single-bit comparator cell used by the serial scan.
module one_bit_comparator (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic gt,
  output logic eq
);
  assign lt = ~a & b;
  assign gt = a & ~b;
  assign eq = ~(a ^ b);
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per cycle.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: leave SCAN on the first
// mismatching bit instead of always scanning all WIDTH bits.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             busy
);

  // index register is at least one bit wide so WIDTH=1 still elaborates
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t          r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  res_t            r_res, w_res_nxt;

  logic w_abit, w_bbit, w_lt, w_gt, w_eq, w_mismatch;

  assign w_abit = r_a[r_idx];
  assign w_bbit = r_b[r_idx];

  one_bit_comparator u_cell (
    .a  (w_abit),
    .b  (w_bbit),
    .lt (w_lt),
    .gt (w_gt),
    .eq (w_eq)
  );

  assign w_mismatch = w_lt | w_gt;

  // state, operand, index and sticky result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_res   <= RES_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_res   <= w_res_nxt;
    end
  end

  // next-state: accept in IDLE, scan MSB->LSB, hold result until consumed
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_res_nxt   = r_res;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_idx_nxt   = IW'(WIDTH - 1);
          w_res_nxt   = RES_NONE;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // first mismatch decides; a decided result is sticky
        if (r_res == RES_NONE && w_mismatch)
          w_res_nxt = w_gt ? RES_GT : RES_LT;
        if (r_idx == '0) begin
          if (r_res == RES_NONE && w_eq)
            w_res_nxt = RES_EQ;
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (r_res == RES_NONE && w_mismatch)
          w_state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (out_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  // decode is gated so lt/gt/eq stay low outside DONE
  assign {lt, gt, eq} = out_valid ? res_decode(r_res) : LGE_NONE;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator (WIDTH=8).
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       out_valid, out_ready;
  logic       lt, gt, eq, busy;

  int errors = 0;
  int checks = 0;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int LAT_B7 = 2;   // mismatch at bit 7
`else
  localparam int LAT_B7 = 9;
`endif
  localparam int LAT_FULL = 9; // eq or mismatch at bit 0

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .gt        (gt),
    .eq        (eq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {out_valid, busy, in_ready, lt, gt, eq}
  function automatic logic [5:0] status();
    return {out_valid, busy, in_ready, lt, gt, eq};
  endfunction

  // Present one pair (caller is in IDLE, just after an edge), accept it,
  // then wait for out_valid and check latency and result.
  task automatic issue(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input int lat, input logic [2:0] lge, input bit keep_valid);
    int n;
    a = av; b = bv; in_valid = 1'b1;
    tick();
    if (!keep_valid) in_valid = 1'b0;
    n = 1;
    chk({tag, "_scan"}, 32'(status()), 32'(6'b010000));
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_res"}, 32'({lt, gt, eq}), 32'(lge));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    chk("reset", 32'(status()), 32'(6'b001000));
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 32'(status()), 32'(6'b001000));

    // equal operands: full scan
    issue("eq_a5", 8'hA5, 8'hA5, LAT_FULL, 3'b001, 1'b0);
    tick();
    chk("eq_a5_idle", 32'(status()), 32'(6'b001000));

    // mismatch at MSB
    issue("gt_80", 8'h80, 8'h7F, LAT_B7, 3'b010, 1'b0);
    tick();
    // mismatch only at LSB
    issue("lt_12", 8'h12, 8'h13, LAT_FULL, 3'b100, 1'b0);
    tick();

    // backpressure: result held, in_valid ignored
    out_ready = 1'b0;
    issue("gt_01", 8'h01, 8'h00, LAT_FULL, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 8'h00; b = 8'hFF;
      tick();
      chk("hold_status", 32'(status()), 32'(6'b110010));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_release", 32'(status()), 32'(6'b001000));
    tick();
    chk("hold_no_accept", 32'(status()), 32'(6'b001000));

    // async reset mid-SCAN
    a = 8'h55; b = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();   // now in 4th SCAN cycle
    chk("pre_abort_busy", 32'(status()), 32'(6'b010000));
    #2 rst = 1'b1;
    #1 chk("abort_scan", 32'(status()), 32'(6'b001000));
    tick();
    rst = 1'b0;
    tick();
    chk("abort_no_result", 32'(status()), 32'(6'b001000));
    issue("lt_00", 8'h00, 8'hFF, LAT_B7, 3'b100, 1'b0);
    tick();

    // async reset with a pending result in DONE
    out_ready = 1'b0;
    issue("done_gt", 8'h03, 8'h02, LAT_FULL, 3'b010, 1'b0);
    #2 rst = 1'b1;
    #1 chk("abort_done", 32'(status()), 32'(6'b001000));
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("abort_done_idle", 32'(status()), 32'(6'b001000));

    // three back-to-back pairs with in_valid held high
    issue("b2b0", 8'h33, 8'h32, LAT_FULL, 3'b010, 1'b1);
    tick();
    chk("b2b0_idle", 32'(status()), 32'(6'b001000));
    issue("b2b1", 8'h40, 8'h40, LAT_FULL, 3'b001, 1'b1);
    tick();
    chk("b2b1_idle", 32'(status()), 32'(6'b001000));
    issue("b2b2", 8'hFE, 8'hFF, LAT_FULL, 3'b100, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("b2b2_idle", 32'(status()), 32'(6'b001000));
    tick();
    chk("final_idle", 32'(status()), 32'(6'b001000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
